// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core and a DMA engine, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of core priority with a starvation guard.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_core_req,
  input  logic        i_core_we,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_core_wdata,
  output logic        o_core_ack,
  output logic [31:0] o_core_rdata,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  output logic        o_dma_ack,
  output logic [31:0] o_dma_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_owner,
  output logic        o_busy
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StAck   = 2'd3;

  logic [1:0]      r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_owner;
  logic            r_mem_we;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [31:0]     r_core_rdata;
  logic [31:0]     r_dma_rdata;

  logic w_any_req;
  logic w_grant_dma;
  logic w_arb;

  assign w_any_req = i_core_req | i_dma_req;
  assign w_arb     = (r_state == StIdle) & w_any_req;

`ifdef MEM_ARB_RR_EN
  // Set when the core took the last grant, so the DMA wins the next tie.
  logic r_rr_dma;

  assign w_grant_dma = i_dma_req & (~i_core_req | r_rr_dma);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_dma <= 1'b0;
    end else if (w_arb) begin
      r_rr_dma <= ~w_grant_dma;
    end
  end
`else
  localparam int unsigned StvW = $clog2(STARVE_MAX + 1);

  logic [StvW-1:0] r_starve;
  logic            w_starved;

  assign w_starved   = (r_starve == StvW'(STARVE_MAX));
  assign w_grant_dma = i_dma_req & (~i_core_req | w_starved);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_arb) begin
      if (w_grant_dma) begin
        r_starve <= '0;
      end else if (i_dma_req && !w_starved) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_dma_rdata  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner     <= w_grant_dma;
            r_mem_we    <= w_grant_dma ? i_dma_we    : i_core_we;
            r_mem_addr  <= w_grant_dma ? i_dma_addr  : i_core_addr;
            r_mem_wdata <= w_grant_dma ? i_dma_wdata : i_core_wdata;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= CntW'(MEM_LAT);
          r_state <= StWait;
        end
        StWait: begin
          r_cnt <= r_cnt - 1'b1;
          // Data is valid on the last wait cycle; writes capture it too.
          if (r_cnt == CntW'(1)) begin
            if (r_owner) begin
              r_dma_rdata <= i_mem_rdata;
            end else begin
              r_core_rdata <= i_mem_rdata;
            end
            r_state <= StAck;
          end
        end
        StAck: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_mem_en     = (r_state == StIssue);
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_core_ack   = (r_state == StAck) & ~r_owner;
  assign o_dma_ack    = (r_state == StAck) & r_owner;
  assign o_core_rdata = r_core_rdata;
  assign o_dma_rdata  = r_dma_rdata;
  assign o_owner      = r_owner;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level model. Follows MEM_ARB_RR_EN like the design.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        o_core_ack, o_dma_ack, o_mem_en, o_mem_we, o_owner, o_busy;
  logic [31:0] o_core_rdata, o_dma_rdata, o_mem_addr, o_mem_wdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] rd_at [int];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_core_req  (core_req),
    .i_core_we   (core_we),
    .i_core_addr (core_addr),
    .i_core_wdata(core_wdata),
    .o_core_ack  (o_core_ack),
    .o_core_rdata(o_core_rdata),
    .i_dma_req   (dma_req),
    .i_dma_we    (dma_we),
    .i_dma_addr  (dma_addr),
    .i_dma_wdata (dma_wdata),
    .o_dma_ack   (o_dma_ack),
    .o_dma_rdata (o_dma_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_owner     (o_owner),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_mem;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_mem;
    int          exp_core_ack;
    int          exp_dma_ack;
    int          exp_dma_en;
  } vec_t;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: lands mid-cycle, then services the memory as the environment would.
  task automatic tick();
    logic [31:0] d;
    @(negedge clk);
    cyc++;
    if (rst && o_mem_en) begin
      d = env_mem.exists(o_mem_addr) ? env_mem[o_mem_addr] : mem_default(o_mem_addr);
      if (o_mem_we) env_mem[o_mem_addr] = o_mem_wdata;
      rd_at[cyc + int'(MEM_LAT)] = d;
    end
    if (rd_at.exists(cyc)) begin
      mem_rdata = rd_at[cyc];
      rd_at.delete(cyc);
    end else begin
      mem_rdata = $urandom;
    end
  endtask

  task automatic drive_idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {o_core_ack, o_dma_ack, o_mem_en, o_mem_we, o_owner, o_busy}, '0);
    chk({tag, "_core_rdata"}, o_core_rdata, '0);
    chk({tag, "_dma_rdata"}, o_dma_rdata, '0);
    chk({tag, "_mem_addr"}, o_mem_addr, '0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_req = 1'($urandom_range(0, 1)); core_we = 1'($urandom_range(0, 1));
      core_addr = $urandom; core_wdata = $urandom;
      dma_req = 1'($urandom_range(0, 1)); dma_we = 1'($urandom_range(0, 1));
      dma_addr = $urandom; dma_wdata = $urandom;
      #1;
      check_zero("rst_hold");
      tick();
    end
    drive_idle();
    rd_at.delete();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_zero("rst_release");
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int c_ack, d_ack, d_en, c_n, d_n;
    logic [31:0] c_rd, d_rd, c_en_addr;
    logic c_en_we;
    string p;
    p = $sformatf("v%0d", k);
    do_reset();
    env_mem.delete();
    env_mem[v.core_addr] = v.core_mem;
    env_mem[v.dma_addr]  = v.dma_mem;
    c_ack = -1; d_ack = -1; d_en = -1; c_n = 0; d_n = 0;
    c_rd = '0; d_rd = '0; c_en_addr = '0; c_en_we = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (o_core_ack) begin
        c_n++;
        if (c_ack < 0) begin c_ack = t; c_rd = o_core_rdata; end
      end
      if (o_dma_ack) begin
        d_n++;
        if (d_ack < 0) begin d_ack = t; d_rd = o_dma_rdata; end
      end
      if (o_mem_en) begin
        if (o_owner) begin
          if (d_en < 0) d_en = t;
        end else begin
          c_en_addr = o_mem_addr; c_en_we = o_mem_we;
        end
      end
      core_req = v.core_req && (c_ack < 0 || t == c_ack);
      core_we = v.core_we; core_addr = v.core_addr; core_wdata = v.core_wdata;
      dma_req = v.dma_req && (d_ack < 0 || t == d_ack);
      dma_we = v.dma_we; dma_addr = v.dma_addr; dma_wdata = v.dma_wdata;
    end
    drive_idle();
    chk({p, "_core_ack_cyc"}, c_ack, v.exp_core_ack);
    chk({p, "_dma_ack_cyc"}, d_ack, v.exp_dma_ack);
    chk({p, "_dma_en_cyc"}, d_en, v.exp_dma_en);
    chk({p, "_core_ack_cnt"}, c_n, (v.exp_core_ack >= 0) ? 1 : 0);
    chk({p, "_dma_ack_cnt"}, d_n, (v.exp_dma_ack >= 0) ? 1 : 0);
    if (v.core_req) begin
      chk({p, "_core_rdata"}, c_rd, v.core_mem);
      chk({p, "_core_mem_addr"}, c_en_addr, v.core_addr);
      chk({p, "_core_mem_we"}, c_en_we, v.core_we);
      if (v.core_we) chk({p, "_core_wr"}, env_mem[v.core_addr], v.core_wdata);
    end
    if (v.dma_req) begin
      chk({p, "_dma_rdata"}, d_rd, v.dma_mem);
      if (v.dma_we) chk({p, "_dma_wr"}, env_mem[v.dma_addr], v.dma_wdata);
    end
  endtask

  task automatic run_starve();
    int n;
    logic exp;
    logic g [$];
    do_reset();
    core_req = 1'b1; core_addr = 32'h10;
    dma_req  = 1'b1; dma_addr  = 32'h20;
    for (int t = 0; t < 80 && g.size() < 10; t++) begin
      tick();
      if (o_mem_en) g.push_back(o_owner);
    end
    drive_idle();
    n = g.size();
    chk("starve_grant_count", n, 10);
    for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_RR_EN
      exp = (i % 2) == 1;
`else
      exp = (i % int'(STARVE_MAX + 1)) == int'(STARVE_MAX);
`endif
      chk($sformatf("starve_grant%0d", i), g[i], exp);
    end
  endtask

  task automatic run_midop_reset();
    do_reset();
    core_req = 1'b1; core_addr = 32'h500; core_we = 1'b0;
    tick();
    tick();
    tick();
    chk("midop_in_wait", o_busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("midop_busy_rst", o_busy, 1'b0);
    chk("midop_ack_rst", o_core_ack, 1'b0);
    drive_idle();
    rd_at.delete();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midop_after", {o_core_ack, o_dma_ack, o_busy, o_mem_en}, '0);
    end
  endtask

  task automatic run_random(input int ncyc);
    logic pend [2], granted [2];
    int   ackc [2];
    logic f_we [2];
    logic [31:0] f_addr [2], f_wdata [2];
    logic [31:0] ref_mem [logic [31:0]];
    logic have, own, t_we, win, busy_e;
    logic [31:0] t_addr, t_wdata, t_rd;
    int gc, ack_t, free_c, starve, t;
    logic last_dma;
    do_reset();
    env_mem.delete();
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; granted[r] = 1'b0; ackc[r] = -1;
      f_we[r] = 1'b0; f_addr[r] = '0; f_wdata[r] = '0;
    end
    have = 1'b0; own = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_rd = '0;
    gc = -100; free_c = 0; starve = 0; last_dma = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      t = cyc;
      ack_t = gc + 2 + int'(MEM_LAT);
      busy_e = have && t >= gc + 1 && t <= ack_t;
      chk("rnd_busy", o_busy, busy_e);
      chk("rnd_mem_en", o_mem_en, have && t == gc + 1);
      if (busy_e) begin
        chk("rnd_owner", o_owner, own);
        chk("rnd_mem_we", o_mem_we, t_we);
        chk("rnd_mem_addr", o_mem_addr, t_addr);
        chk("rnd_mem_wdata", o_mem_wdata, t_wdata);
      end
      chk("rnd_core_ack", o_core_ack, have && t == ack_t && !own);
      chk("rnd_dma_ack", o_dma_ack, have && t == ack_t && own);
      if (have && t == ack_t)
        chk("rnd_rdata", own ? o_dma_rdata : o_core_rdata, t_rd);
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && granted[r] && t > ackc[r]) begin
          pend[r] = 1'b0; granted[r] = 1'b0;
        end
        if ((!pend[r] && $urandom_range(0, 2) == 0) ||
            (pend[r] && !granted[r] && $urandom_range(0, 3) == 0)) begin
          pend[r]    = 1'b1;
          f_we[r]    = 1'($urandom_range(0, 1));
          f_addr[r]  = 32'($urandom_range(0, 15)) << 2;
          f_wdata[r] = $urandom;
        end
      end
      core_req = pend[0]; core_we = f_we[0]; core_addr = f_addr[0]; core_wdata = f_wdata[0];
      dma_req  = pend[1]; dma_we  = f_we[1]; dma_addr  = f_addr[1]; dma_wdata  = f_wdata[1];
      if (t >= free_c && (pend[0] || pend[1])) begin
`ifdef MEM_ARB_RR_EN
        win = pend[1] && (!pend[0] || !last_dma);
`else
        win = pend[1] && (!pend[0] || starve == int'(STARVE_MAX));
        if (win) starve = 0;
        else if (pend[1] && starve < int'(STARVE_MAX)) starve++;
`endif
        last_dma = win;
        own = win; gc = t; have = 1'b1;
        t_we = f_we[win]; t_addr = f_addr[win]; t_wdata = f_wdata[win];
        t_rd = ref_mem.exists(t_addr) ? ref_mem[t_addr] : mem_default(t_addr);
        if (t_we) ref_mem[t_addr] = t_wdata;
        granted[win] = 1'b1;
        ackc[win] = t + 2 + int'(MEM_LAT);
        free_c = t + 3 + int'(MEM_LAT);
      end
    end
    drive_idle();
  endtask

  initial begin
    vec_t vecs [4];
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF,
                1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4, -1, -1};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 32'h200, 32'h0, 32'h1234_5678, -1, 4, 1};
    vecs[2] = '{1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h1111_1111,
                1'b1, 1'b0, 32'h80, 32'h0, 32'h2222_2222, 4, 9, 6};
    vecs[3] = '{1'b1, 1'b0, 32'h304, 32'h0, 32'h4444_4444,
                1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5, 32'h3333_3333, 4, 9, 6};

    do_reset();
    for (int k = 0; k < 4; k++) run_vec(vecs[k], k);
    run_starve();
    run_midop_reset();
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port unified memory shared by two requesters: the multicycle core and a DMA/boot-loader engine.
- The core requester carries instruction fetch and load/store traffic.
- The block grants one requester per transaction, issues a one-cycle memory command and waits the fixed memory latency. It then returns read data with a one-cycle ack.
- The core control FSM stalls its fetch and memory states until core_ack.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata; must be >=1.
- STARVE_MAX, 4, number of consecutive core wins over a pending DMA request before the DMA is forced to win; must be >=1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- core_req  input  1  core transaction request; held with its fields until core_ack
- core_we  input  1  core write enable (1 = store)
- core_addr  input  32  core byte address
- core_wdata  input  32  core write data
- core_ack  output  1  one-cycle completion pulse to core
- core_rdata  output  32  read data, valid while core_ack=1
- dma_req  input  1  DMA request, same rules as core_req
- dma_we  input  1  DMA write enable
- dma_addr  input  32  DMA address
- dma_wdata  input  32  DMA write data
- dma_ack  output  1  one-cycle completion pulse to DMA
- dma_rdata  output  32  read data, valid while dma_ack=1
- mem_en  output  1  memory command strobe
- mem_we  output  1  memory write enable
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data
- owner  output  1  current grant holder (0 = core, 1 = DMA); meaningful while busy=1
- busy  output  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0: acks, rdata, mem_* and owner. Wait counter and starvation counter are 0.
- Reset mid-transaction abandons the in-flight operation; no ack is ever produced for it.
- States and transitions:
  - IDLE: arbitrate. If any req, latch the winner's we/addr/wdata into the mem_* registers, set owner, go to ISSUE. Otherwise stay.
  - ISSUE: mem_en=1 for exactly this cycle; load the wait counter with MEM_LAT; go to WAIT.
  - WAIT: decrement the counter each cycle. In the last WAIT cycle (MEM_LAT cycles after ISSUE), capture mem_rdata into the owner's rdata register, also on writes. Go to ACK.
  - ACK: assert the owner's ack for one cycle; the other ack stays 0; go to IDLE. req inputs are ignored in ACK.
- mem_we, mem_addr and mem_wdata are held constant from ISSUE through ACK. mem_en is 0 outside ISSUE.
- Latency: req sampled in IDLE at cycle c gives ISSUE at c+1 and ack at c+2+MEM_LAT. Reads and writes have identical timing.
- The requester drops or renews req in the cycle after ack. Back-to-back transfers incur one IDLE bubble.
- core_rdata and dma_rdata hold their last captured value after ack.
- Arbitration (default):
  - Only one requester pending: it wins.
  - Both pending: the core wins unless starve_cnt==STARVE_MAX, in which case the DMA wins.
- Starvation counter:
  - Increments on every IDLE decision where both requested and the core won.
  - Clears when the DMA is granted.
  - Saturates at STARVE_MAX.
- Request fields changing while req=1 before grant are tolerated. The values sampled in the granting IDLE cycle are used.

Optional Feature:
- MEM_ARB_RR_EN defined: the starvation counter is removed and ties go round-robin. The requester not granted last wins; after reset the core has priority.
- MEM_ARB_RR_EN undefined: core-priority arbitration with the STARVE_MAX guard as above.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, busy=0. Release -> outputs stay 0 until a req arrives.
- Core read alone, MEM_LAT=2: core_req, core_addr=0x100 at cycle 0; memory returns 0xDEADBEEF -> mem_en=1, mem_addr=0x100 at cycle 1, core_ack=1 and core_rdata=0xDEADBEEF at cycle 4, dma_ack never asserted.
- Simultaneous: core write 0x40 and DMA read 0x80 at cycle 0 -> core granted first, core_ack at cycle 4; DMA's mem_en at cycle 6, dma_ack at cycle 9.
- Starvation, STARVE_MAX=4: both req held continuously -> grant order core, core, core, core, DMA, core...; starve_cnt returns to 0 after the DMA grant.
- Reset mid-op: assert rst=0 during WAIT of a core read -> no core_ack. After release, busy=0 and mem_en=0 until a new req.
- Build with MEM_ARB_RR_EN, both req continuous -> grants strictly alternate core, DMA, core, DMA from reset.
